regfile_mp: RTL

Parametrised multi-port integer register file with write-to-read bypass and a per-register pending-write scoreboard. It is the successor to the single-write, two-read pipeline register file. It sits between decode (read ports and scoreboard issue) and writeback (write ports). Width, depth, read-port count and write-port count are generics so the same block serves the scalar and dual-issue pipelines.

---
 rtl/regfile_mp.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass
// and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NWR-1:0]      wclr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                wcollide
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic [AW-1:0]   wa_a [NWR];
  logic [XLEN-1:0] wd_a [NWR];
  logic [NWR-1:0]  wv;

  // wv marks ports whose write actually lands (x0 writes dropped)
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa_a[j] = wa[j*AW +: AW];
      wd_a[j] = wd[j*XLEN +: XLEN];
      wv[j]   = we[j] &&
                !((ZERO_REG != 0) && (wa_a[j] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wv[j]) begin
          mem_q[wa_a[j]] <= wd_a[j];
        end
      end
    end
  end

  // issue applied after clears: a new producer supersedes the old
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wv[j] && wclr[j]) begin
        busy_d[wa_a[j]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            c;
    logic            z;

    assign a = ra[i*AW +: AW];
    assign z = (ZERO_REG != 0) && (a == '0);

    always_comb begin
      d = mem_q[a];
      c = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wv[j] && (wa_a[j] == a)) begin
          if (BYPASS != 0) begin
            d = wd_a[j];
          end
          if (wclr[j]) begin
            c = 1'b1;
          end
        end
      end
    end

    assign rd[i*XLEN +: XLEN] = (!rst_n || z) ? '0 : d;
    assign rbusy[i] = rst_n && busy_q[a] &&
                      !((BYPASS != 0) && c);
  end

  if (NWR == 2) begin : g_col
    assign wcollide = wv[0] && wv[1] &&
                      (wa_a[0] == wa_a[1]);
  end else begin : g_nocol
    assign wcollide = 1'b0;
  end

endmodule
